if_fetch_unit: RTL and testbench

Instruction-fetch stage that drives the IF/ID pipeline register from the producer side. It owns the program counter and issues requests to instruction memory over a req/ack handshake. It presents each fetched instruction with its PC+4 to IF/ID, and honours the hazard unit's keep (stall) and branch redirect/flush. When no instruction is ready, it emits a NOP bubble so IF/ID never latches stale data.

---
 rtl/if_fetch_unit.sv | 117 +++++++++++
 tb/tb_if_fetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and feeds IF/ID.
// Optional feature macro FETCH_ALIGN_CHECK_EN: flag misaligned redirect targets on fetch_err_o.
module if_fetch_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              keep_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic [DATA_W-1:0] ins_o,
  output logic [ADDR_W-1:0] next_addr_o,
  output logic              ins_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              fetch_err_o
);

  typedef enum logic [1:0] {S_RESET, S_REQ, S_HOLD, S_SQUASH} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] ins_q, ins_d;
  logic [ADDR_W-1:0] redir_pc;
  logic [ADDR_W-1:0] pc_inc;

  assign redir_pc = {redirect_addr_i[ADDR_W-1:2], 2'b00};
  assign pc_inc   = pc_q + ADDR_W'(4);

  // NOTE: every signal gets its hold value first, so no path through the case can infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    ins_d      = ins_q;
    unique case (state_q)
      S_RESET: begin
        state_d = S_REQ;
        if (redirect_i) pc_d = redir_pc;
      end
      S_REQ: begin
        // Remember the in-flight address so a squash keeps presenting it after pc moves.
        req_addr_d = pc_q;
        if (redirect_i) begin
          pc_d    = redir_pc;
          state_d = imem_ack_i ? S_REQ : S_SQUASH;
        end else if (imem_ack_i) begin
          ins_d   = imem_rdata_i;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          pc_d    = redir_pc;
          state_d = S_REQ;
        end else if (!keep_i) begin
          pc_d    = pc_inc;
          state_d = S_REQ;
        end
      end
      S_SQUASH: begin
        if (redirect_i) pc_d = redir_pc;
        if (imem_ack_i) state_d = S_REQ;
      end
      default: state_d = S_RESET;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_RESET;
      pc_q       <= RESET_ADDR;
      req_addr_q <= RESET_ADDR;
      ins_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      ins_q      <= ins_d;
    end
  end

  assign imem_req_o  = (state_q == S_REQ) || (state_q == S_SQUASH);
  assign imem_addr_o = (state_q == S_SQUASH) ? req_addr_q : pc_q;
  assign ins_valid_o = (state_q == S_HOLD);
  assign ins_o       = ins_valid_o ? ins_q  : '0;
  assign next_addr_o = ins_valid_o ? pc_inc : '0;
  assign pc_o        = pc_q;

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (redirect_i && (redirect_addr_i[1:0] != 2'b00)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign fetch_err_o = err_q;
`else
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_addr_i[1:0];
  assign fetch_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus random keep/redirect/latency traffic,
// scored against an architectural PC-stream model and a behavioural instruction memory.
module tb_if_fetch_unit;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam logic [31:0] RESET_ADDR = 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        keep_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_addr_i = '0;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] ins_o;
  logic [31:0] next_addr_o;
  logic        ins_valid_o;
  logic [31:0] pc_o;
  logic        fetch_err_o;

  int          n_tests = 0;
  int          n_fail = 0;
  int          lat_cfg = 0;
  logic [31:0] exp_q[$];
  logic        exp_err = 1'b0;
  logic        cur_valid = 1'b0;
  int          idle_cycles = 0;
  bit          found;
  logic        pat_valid[6];
  logic [31:0] pat_next[6];
  logic [31:0] tgt;

  if_fetch_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_ADDR(RESET_ADDR)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .keep_i(keep_i),
    .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .ins_o(ins_o), .next_addr_o(next_addr_o), .ins_valid_o(ins_valid_o),
    .pc_o(pc_o), .fetch_err_o(fetch_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Distinct, address-derived instruction word for every address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1F2E;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change here, one unit after the memory responder acts.
  task automatic next_cyc();
    @(negedge clk_i);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(imem_req_o),  32'd0);
    check({tag, "_addr"},  imem_addr_o,      RESET_ADDR);
    check({tag, "_ins"},   ins_o,            32'd0);
    check({tag, "_next"},  next_addr_o,      32'd0);
    check({tag, "_valid"}, 32'(ins_valid_o), 32'd0);
    check({tag, "_pc"},    pc_o,             RESET_ADDR);
    check({tag, "_err"},   32'(fetch_err_o), 32'd0);
  endtask

  // Instruction memory: answers a request after lat_cfg wait cycles.
  initial begin : mem_model
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk_i);
      #1;
      imem_ack_i = 1'b0;
      if (!rst_n_i || !imem_req_o) begin
        wcnt = 0;
      end else if (wcnt >= lat_cfg) begin
        imem_ack_i   = 1'b1;
        imem_rdata_i = mem_word(imem_addr_o);
        wcnt         = 0;
      end else begin
        wcnt++;
      end
    end
  end

  // Architectural model: the PC advances by 4 per consumed instruction, jumps on redirect.
  initial begin : ref_model
    logic [31:0] a;
    exp_q = {RESET_ADDR};
    forever begin
      @(posedge clk_i or negedge rst_n_i);
      if (!rst_n_i) begin
        exp_q   = {RESET_ADDR};
        exp_err = 1'b0;
      end else if (redirect_i) begin
        exp_q.delete();
        exp_q.push_back(redirect_addr_i & ~32'h3);
        if (ALIGN_CHK && (redirect_addr_i[1:0] != 2'b00)) exp_err = 1'b1;
      end else if (cur_valid && !keep_i) begin
        a = exp_q.pop_front();
        exp_q.push_back(a + 32'd4);
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the head of the expected stream.
  initial begin : monitor
    logic        last_req;
    logic [31:0] last_addr;
    last_req  = 1'b0;
    last_addr = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        last_req    = 1'b0;
        cur_valid   = 1'b0;
        idle_cycles = 0;
        continue;
      end
      cur_valid = ins_valid_o;
      check("pc_o", pc_o, exp_q[0]);
      if (ins_valid_o) begin
        check("ins_o", ins_o, mem_word(exp_q[0]));
        check("next_addr_o", next_addr_o, exp_q[0] + 32'd4);
      end else begin
        check("bubble_ins_o", ins_o, 32'd0);
        check("bubble_next_addr_o", next_addr_o, 32'd0);
      end
      check("fetch_err_o", 32'(fetch_err_o), 32'(exp_err));
      if (last_req && !imem_ack_i) begin
        check("req_held_until_ack", 32'(imem_req_o), 32'd1);
        check("req_addr_stable", imem_addr_o, last_addr);
      end
      if (imem_req_o) check("req_addr_aligned", 32'(imem_addr_o[1:0]), 32'd0);
      if (ins_valid_o || redirect_i) idle_cycles = 0;
      else idle_cycles++;
      check("progress_bound", 32'(idle_cycles <= 16), 32'd1);
      last_req  = imem_req_o;
      last_addr = imem_addr_o;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL timeout: bench did not finish (%0d tests so far)", n_tests);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    pat_valid = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    pat_next  = '{32'h0, 32'h4, 32'h0, 32'h8, 32'h0, 32'hC};

    repeat (2) next_cyc();
    check_reset_outputs("reset");
    rst_n_i = 1'b1;

    // Zero-wait memory: one instruction every second cycle.
    for (int i = 0; i < 6; i++) begin
      next_cyc();
      if (i == 0) begin
        check("first_req", 32'(imem_req_o), 32'd1);
        check("first_req_addr", imem_addr_o, RESET_ADDR);
      end
      check("stream_valid", 32'(ins_valid_o), 32'(pat_valid[i]));
      check("stream_next_addr", next_addr_o, pat_next[i]);
    end

    // Stall three cycles in S_HOLD at pc 0x8.
    keep_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      check("keep_valid", 32'(ins_valid_o), 32'd1);
      check("keep_next_addr", next_addr_o, 32'hC);
      check("keep_no_req", 32'(imem_req_o), 32'd0);
    end
    keep_i = 1'b0;
    next_cyc();
    check("after_keep_req", 32'(imem_req_o), 32'd1);
    check("after_keep_addr", imem_addr_o, 32'hC);

    // Slow memory, redirect in the first request cycle of 0x10.
    lat_cfg = 3;
    next_cyc();
    next_cyc();
    check("slow_req_addr", imem_addr_o, 32'h10);
    redirect_i = 1'b1;
    redirect_addr_i = 32'h40;
    next_cyc();
    redirect_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("squash_req", 32'(imem_req_o), 32'd1);
      check("squash_old_addr", imem_addr_o, 32'h10);
      check("squash_no_valid", 32'(ins_valid_o), 32'd0);
      if (i < 2) next_cyc();
    end
    lat_cfg = 0;
    next_cyc();
    check("post_squash_addr", imem_addr_o, 32'h40);
    check("post_squash_no_valid", 32'(ins_valid_o), 32'd0);
    next_cyc();
    check("target_delivered", next_addr_o, 32'h44);

    // Redirect wins over keep in S_HOLD at pc 0x20.
    redirect_i = 1'b1;
    redirect_addr_i = 32'h20;
    next_cyc();
    redirect_i = 1'b0;
    next_cyc();
    check("hold_at_0x20", next_addr_o, 32'h24);
    keep_i = 1'b1;
    redirect_i = 1'b1;
    redirect_addr_i = 32'h100;
    next_cyc();
    keep_i = 1'b0;
    redirect_i = 1'b0;
    check("redirect_over_keep_req", 32'(imem_req_o), 32'd1);
    check("redirect_over_keep_addr", imem_addr_o, 32'h100);

    // Misaligned target: fetch from cleared address, error flag only with the check enabled.
    next_cyc();
    redirect_i = 1'b1;
    redirect_addr_i = 32'h102;
    next_cyc();
    redirect_i = 1'b0;
    check("misaligned_req_addr", imem_addr_o, 32'h100);
    for (int i = 0; i < 4; i++) begin
      check("misaligned_err_sticky", 32'(fetch_err_o), 32'(ALIGN_CHK));
      next_cyc();
    end

    // PC+4 wraps at the top of the address space.
    redirect_i = 1'b1;
    redirect_addr_i = 32'hFFFF_FFF8;
    next_cyc();
    redirect_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      next_cyc();
      if (ins_valid_o && pc_o == 32'hFFFF_FFFC) begin
        found = 1'b1;
        check("wrap_next_addr", next_addr_o, 32'h0);
      end
    end
    check("wrap_seen", 32'(found), 32'd1);

    // Asynchronous reset while waiting on memory at 0x44.
    lat_cfg = 3;
    redirect_i = 1'b1;
    redirect_addr_i = 32'h44;
    next_cyc();
    redirect_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      next_cyc();
      if (imem_req_o && imem_addr_o == 32'h44 && pc_o == 32'h44) found = 1'b1;
    end
    check("wait_at_0x44", 32'(found), 32'd1);
    #1 rst_n_i = 1'b0;
    #1 check_reset_outputs("async_reset");
    lat_cfg = 0;
    repeat (2) next_cyc();
    rst_n_i = 1'b1;
    next_cyc();
    check("restart_req", 32'(imem_req_o), 32'd1);
    check("restart_addr", imem_addr_o, RESET_ADDR);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      next_cyc();
      keep_i     = ($urandom % 4) == 0;
      redirect_i = ($urandom % 10) == 0;
      lat_cfg    = int'($urandom % 4);
      if (($urandom % 4) == 0) begin
        tgt = 32'hFFFF_FFF0 + ($urandom % 16);
      end else begin
        tgt = $urandom_range(0, 4095);
        if (($urandom % 4) != 0) tgt[1:0] = 2'b00;
      end
      redirect_addr_i = tgt;
    end
    keep_i = 1'b0;
    redirect_i = 1'b0;
    lat_cfg = 0;
    repeat (10) next_cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
